// File: rtl/banco_fifos_salida.sv
// banco_fifos_salida: four-lane output FIFO bank at the receive end of the
// transaction layer. One-hot Push writes the shared data word into a lane.
// Each lane is drained independently by Pop, with registered read data.
// Optional feature: define SALIDA_ERR_EN to compile in the sticky per-lane
// overflow/underflow error register. Without it, error is tied low.
module banco_fifos_salida #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Enable,
  input  logic [3:0]            Push,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [3:0]            Pop,
  output logic [4*DATA_W-1:0]   data_out,
  output logic [3:0]            valid_out,
  output logic [3:0]            FIFO_empty,
  output logic [3:0]            FIFO_full,
  output logic [3:0]            Almost_full,
  output logic [3:0]            error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);

  logic [3:0]        push_sel;
  logic [3:0]        push_ok;
  logic [3:0]        pop_ok;
  logic [PTR_W-1:0]  wptr [4];
  logic [PTR_W-1:0]  rptr [4];
  logic [CNT_W-1:0]  cnt  [4];
  logic [DATA_W-1:0] mem  [4][DEPTH];
  logic [DATA_W-1:0] data_p1 [4];
  logic [3:0]        vld_p1;

  // An illegal multi-hot Push only writes its lowest set lane.
  assign push_sel = Push & (~Push + 4'd1);

  // Accept decisions: a pop on a full lane frees the slot the push needs.
  always_comb begin
    pop_ok  = '0;
    push_ok = '0;
    for (int i = 0; i < 4; i++) begin
      pop_ok[i]  = Enable & Pop[i] & (cnt[i] != '0);
      push_ok[i] = Enable & push_sel[i] & ((cnt[i] != DEPTH_C) | pop_ok[i]);
    end
  end

  // Lane storage: plain data, written only on an accepted push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_ok[i]) mem[i][wptr[i]] <= data_in;
    end
  end

  // Pointers, occupancy and registered read port (stage p1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wptr[i]    <= '0;
        rptr[i]    <= '0;
        cnt[i]     <= '0;
        data_p1[i] <= '0;
      end
      vld_p1 <= '0;
    end else begin
      vld_p1 <= pop_ok;
      for (int i = 0; i < 4; i++) begin
        if (pop_ok[i]) begin
          data_p1[i] <= mem[i][rptr[i]];
          rptr[i]    <= rptr[i] + PTR_W'(1);
        end
        if (push_ok[i]) wptr[i] <= wptr[i] + PTR_W'(1);
        case ({push_ok[i], pop_ok[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      assign data_out[g*DATA_W +: DATA_W] = data_p1[g];
      assign FIFO_empty[g]  = (cnt[g] == '0);
      assign FIFO_full[g]   = (cnt[g] == DEPTH_C);
      assign Almost_full[g] = (cnt[g] >= AF_C);
    end
  endgenerate

  assign valid_out = vld_p1;

`ifdef SALIDA_ERR_EN
  logic [3:0] err_q;
  logic [3:0] err_set;

  // Flag lanes named by a multi-hot Push, dropped pushes and empty pops.
  always_comb begin
    err_set = '0;
    for (int i = 0; i < 4; i++) begin
      err_set[i] = Enable & ((Push[i] & ~push_sel[i]) |
                             (push_sel[i] & ~push_ok[i]) |
                             (Pop[i] & (cnt[i] == '0)));
    end
  end

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= '0;
    else       err_q <= err_q | err_set;
  end

  assign error = err_q;
`else
  assign error = 4'b0000;
`endif

endmodule

// File: tb/tb_banco_fifos_salida.sv
// Self-checking bench for banco_fifos_salida: queue-based lane model plus
// hand-computed expectations for fill, drain, wrap, collisions and reset.
module tb_banco_fifos_salida;
  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
`ifdef SALIDA_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          Enable;
  logic [3:0]    Push;
  logic [DW-1:0] data_in;
  logic [3:0]    Pop;
  logic [4*DW-1:0] data_out;
  logic [3:0]    valid_out;
  logic [3:0]    FIFO_empty;
  logic [3:0]    FIFO_full;
  logic [3:0]    Almost_full;
  logic [3:0]    error;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;

  // Model state: per-lane contents, last read word, valid pulse, sticky error.
  logic [DW-1:0] q [4][$];
  logic [DW-1:0] m_do [4];
  logic [3:0]    m_v;
  logic [3:0]    m_err;

  logic [4*DW-1:0] snap_do;
  logic [3:0]      snap_empty;
  logic [3:0]      snap_err;

  banco_fifos_salida #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .reset(reset), .Enable(Enable), .Push(Push), .data_in(data_in),
    .Pop(Pop), .data_out(data_out), .valid_out(valid_out),
    .FIFO_empty(FIFO_empty), .FIFO_full(FIFO_full),
    .Almost_full(Almost_full), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane(input int n);
    return data_out[n*DW +: DW];
  endfunction

  function automatic logic [4*DW-1:0] exp_do();
    logic [4*DW-1:0] v;
    for (int i = 0; i < 4; i++) v[i*DW +: DW] = m_do[i];
    return v;
  endfunction

  function automatic logic [3:0] exp_flag(input int kind);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) begin
      case (kind)
        0:       v[i] = (q[i].size() == 0);
        1:       v[i] = (q[i].size() == DEPTH);
        default: v[i] = (q[i].size() >= AF);
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      m_do[i] = '0;
    end
    m_v   = '0;
    m_err = '0;
  endtask

  // Apply one clock of the lane rules to the model: pops read old contents,
  // then the lowest requested push lands if the lane has room.
  task automatic model_update();
    int low;
    low = -1;
    m_v = '0;
    if (Enable) begin
      for (int i = 0; i < 4; i++) if (Push[i] && low < 0) low = i;
      for (int i = 0; i < 4; i++) begin
        if (Pop[i]) begin
          if (q[i].size() > 0) begin
            m_do[i] = q[i].pop_front();
            m_v[i]  = 1'b1;
          end else m_err[i] = 1'b1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (Push[i]) begin
          if (i != low) m_err[i] = 1'b1;
          else if (q[i].size() < DEPTH) q[i].push_back(data_in);
          else m_err[i] = 1'b1;
        end
      end
    end
  endtask

  // Every cycle, away from the active edge, the DUT must match the model.
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk("data_out",    data_out,    exp_do());
      chk("valid_out",   valid_out,   m_v);
      chk("FIFO_empty",  FIFO_empty,  exp_flag(0));
      chk("FIFO_full",   FIFO_full,   exp_flag(1));
      chk("Almost_full", Almost_full, exp_flag(2));
      chk("error",       error,       m_err & {4{ERR_ON}});
    end
  end

  task automatic step(input logic en, input logic [3:0] ps, input logic [3:0] pp,
                      input logic [DW-1:0] d);
    Enable  = en;
    Push    = ps;
    Pop     = pp;
    data_in = d;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_data_out"},  data_out,    '0);
    chk({tag, "_valid_out"}, valid_out,   4'b0000);
    chk({tag, "_empty"},     FIFO_empty,  4'b1111);
    chk({tag, "_full"},      FIFO_full,   4'b0000);
    chk({tag, "_af"},        Almost_full, 4'b0000);
    chk({tag, "_error"},     error,       4'b0000);
  endtask

  initial begin
    reset = 1'b1; Enable = 1'b0; Push = '0; Pop = '0; data_in = '0;
    model_reset();
    #1;
    check_reset_values("rst0");
    @(posedge clk); @(posedge clk); #1;
    reset  = 1'b0;
    chk_on = 1'b1;

    // Fill lane 2 past its threshold and capacity.
    step(1, 4'b0100, 4'b0000, 6'h11);
    chk("fill1_empty2", FIFO_empty[2], 1'b0);
    chk("fill1_af2", Almost_full[2], 1'b0);
    step(1, 4'b0100, 4'b0000, 6'h12);
    chk("fill2_af2", Almost_full[2], 1'b0);
    step(1, 4'b0100, 4'b0000, 6'h13);
    chk("fill3_af2", Almost_full[2], 1'b1);
    chk("fill3_full2", FIFO_full[2], 1'b0);
    step(1, 4'b0100, 4'b0000, 6'h14);
    chk("fill4_full2", FIFO_full[2], 1'b1);
    step(1, 4'b0100, 4'b0000, 6'h15);
    chk("ovf_error2", error[2], ERR_ON);
    chk("ovf_full2", FIFO_full[2], 1'b1);

    // Drain lane 2 in order.
    for (int k = 0; k < 4; k++) begin
      step(1, 4'b0000, 4'b0100, 6'h00);
      chk("drain_data2", lane(2), 6'h11 + 6'(k));
      chk("drain_valid2", valid_out[2], 1'b1);
    end
    step(1, 4'b0000, 4'b0000, 6'h00);
    chk("drain_idle_valid", valid_out, 4'b0000);
    chk("drain_empty2", FIFO_empty[2], 1'b1);

    // After wrap the pointers are back at slot 0.
    step(1, 4'b0100, 4'b0000, 6'h21);
    step(1, 4'b0000, 4'b0100, 6'h00);
    chk("wrap_data2", lane(2), 6'h21);

    // Multi-hot push: lane 0 wins, lane 1 is flagged.
    step(1, 4'b0011, 4'b0000, 6'h33);
    chk("multi_error1", error[1], ERR_ON);
    chk("multi_empty", FIFO_empty[1:0], 2'b10);
    step(1, 4'b0000, 4'b0001, 6'h00);
    chk("multi_data0", lane(0), 6'h33);

    // Simultaneous push and pop on a full lane 0.
    for (int k = 1; k <= 4; k++) step(1, 4'b0001, 4'b0000, 6'(k));
    chk("l0_full", FIFO_full[0], 1'b1);
    step(1, 4'b0001, 4'b0001, 6'h05);
    chk("pp_valid0", valid_out[0], 1'b1);
    chk("pp_data0", lane(0), 6'h01);
    chk("pp_full0", FIFO_full[0], 1'b1);
    chk("pp_error0", error[0], 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1, 4'b0000, 4'b0001, 6'h00);
      chk("pp_drain0", lane(0), 6'h02 + 6'(k));
    end

    // Empty pop on lane 3 with a same-cycle push: no bypass.
    step(1, 4'b1000, 4'b1000, 6'h2A);
    chk("epop_valid3", valid_out[3], 1'b0);
    chk("epop_error3", error[3], ERR_ON);
    chk("epop_empty3", FIFO_empty[3], 1'b0);
    step(1, 4'b0000, 4'b1000, 6'h00);
    chk("epop_data3", lane(3), 6'h2A);
    chk("epop_v3", valid_out[3], 1'b1);

    // Enable low freezes everything.
    step(1, 4'b0010, 4'b0000, 6'h0F);
    snap_do = data_out; snap_empty = FIFO_empty; snap_err = error;
    step(0, 4'b1000, 4'b1111, 6'h3F);
    chk("en_valid", valid_out, 4'b0000);
    chk("en_data", data_out, snap_do);
    chk("en_empty", FIFO_empty, snap_empty);
    chk("en_error", error, snap_err);
    step(1, 4'b0000, 4'b0010, 6'h00);
    chk("en_data1", lane(1), 6'h0F);

    // Reset mid-clock with words buffered.
    step(1, 4'b0010, 4'b0000, 6'h07);
    step(1, 4'b0100, 4'b0000, 6'h08);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, 4'b0010, 4'b0000, 6'h19);
    chk("post_rst_empty1", FIFO_empty[1], 1'b0);
    step(1, 4'b0000, 4'b0010, 6'h00);
    chk("post_rst_data1", lane(1), 6'h19);
    step(1, 4'b0000, 4'b0000, 6'h00);

    @(posedge clk); #1;
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
